ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Two-requester arbiter and sequencer for one single-port synchronous RAM: the simple RAM with address, write_data, write_en, and read_data registered one cycle after address.
- Optionally clears every RAM entry after reset, then grants one access per cycle to requester A or B (round-robin, with optional burst lock).
- Returns read data to the owning requester with fixed latency.
- Sits between the CPU/ALU-tester datapath (A) and a secondary master such as the display/debug reader (B) and the shared RAM instance.

Parameters:
- SIZE, 8, RAM word width in bits.
- DEPTH, 256, RAM entries; address width AW = $clog2(DEPTH).
- CLEAR_ON_RESET, 1, 1 = write INIT_VALUE to all entries after reset before serving requests.
- INIT_VALUE, 0, SIZE-bit clear pattern.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- a_req  in  1  A requests an access this cycle
- a_lock  in  1  A asks to keep the grant on the next cycle
- a_we  in  1  1 = write, 0 = read
- a_addr  in  AW  A address
- a_wdata  in  SIZE  A write data
- a_ready  out  1  A access accepted this cycle
- a_rvalid  out  1  A read data valid
- a_rdata  out  SIZE  A read data, 0 when a_rvalid=0
- b_req, b_lock, b_we, b_addr, b_wdata, b_ready, b_rvalid, b_rdata  same as A, for B
- ram_address  out  AW  to RAM address
- ram_write_data  out  SIZE  to RAM write_data
- ram_write_en  out  1  to RAM write_en
- ram_read_data  in  SIZE  from RAM read_data
- init_done  out  1  high once arbitration is enabled

Behaviour:
- Reset is asynchronous and active-low, with one clock clk. While rst_n=0:
  - state=INIT if CLEAR_ON_RESET else ARB; init counter=0; last_grant=B.
  - lock_owner=none; rd_pending=0.
  - All outputs 0, init_done=0.
- FSM has two states, INIT and ARB.
- INIT:
  - ram_write_en=1, ram_address=counter, ram_write_data=INIT_VALUE; counter increments each cycle.
  - When counter=DEPTH-1, that write is issued and the next state is ARB. INIT lasts exactly DEPTH cycles.
  - a_ready=b_ready=0 throughout; requests are ignored, not queued.
- ARB: init_done=1 (registered; high from the first ARB cycle).
- Grant is combinational from req, lock_owner and last_grant. At most one grant per cycle.
  - If lock_owner=X and X_req=1, grant X.
  - Otherwise, if only one requester has req=1, grant it.
  - Otherwise, if both request, grant the one that is not last_grant.
  - Otherwise, no grant: ram_write_en=0 and ram_address holds its last value (registered hold).
- Grant effects:
  - X_ready=1 in the same cycle; ram_address, ram_write_en (=X_we) and ram_write_data are driven from X combinationally.
  - A request completes on a cycle with req=1 and ready=1. Requesters hold their inputs until ready.
- On a grant edge:
  - last_grant<=X.
  - lock_owner<=X if X_lock else none.
  - If no grant, lock_owner<=none.
- Read latency: a read granted in cycle t gives X_rvalid=1 and X_rdata=ram_read_data in cycle t+1.
  - rd_pending/rd_owner are registered; a write grant sets rd_pending=0.
  - Back-to-back reads, including alternating owners, are supported at full rate.
- Read-after-write to the same address on consecutive cycles returns the new value. No hazard logic is needed because the write lands at edge t.
- The RAM's read_data during a write cycle is never forwarded; rvalid=0 after a write.
- Reset mid-INIT or mid-ARB aborts immediately:
  - Pending rvalid is dropped.
  - INIT restarts from address 0.

Decomposition:
- Package ram_arb_pkg holds:
  - state enum {INIT, ARB};
  - owner encoding {OWN_NONE, OWN_A, OWN_B};
  - the AW function.
- One natural sub-module: rr_grant2, the combinational 2-way round-robin/lock grant function. Everything else stays in ram_arbiter.
- The RAM itself is instantiated by the parent, not inside this block.

Test Plan:
1. Reset, CLEAR_ON_RESET=1, DEPTH=256, INIT_VALUE=8'h5A:
   - ram_write_en high for exactly 256 cycles with addresses 0..255;
   - init_done rises on cycle 257;
   - a_ready=0 throughout, even with a_req=1.
2. After init, A writes addr 3=8'hC4, then reads addr 3 on the next cycle:
   - a_ready both cycles;
   - a_rvalid=1 with a_rdata=8'hC4 one cycle after the read;
   - b_rvalid=0.
3. A and B both hold read requests for 4 cycles (A addr 1, B addr 2, no lock):
   - grants alternate A,B,A,B;
   - rvalid alternates one cycle later;
   - rdata=0x5A for each owner.
4. a_lock=1 with a_req held for 3 cycles while b_req=1:
   - A is granted 3 consecutive cycles;
   - a_lock drops, and B is granted the next cycle.
5. A read is granted at cycle t and rst_n is pulsed low at t+0.5:
   - a_rvalid=0 at t+1;
   - all outputs are 0 during reset;
   - INIT restarts at address 0.
6. No requests for 5 cycles in ARB:
   - ram_write_en=0;
   - ram_address is unchanged;
   - no rvalid pulses.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types for the two-requester RAM arbiter: FSM states, grant owner
// encoding and the address-width helper.
package ram_arb_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_ARB  = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_A    = 2'd1,
        OWN_B    = 2'd2
    } owner_t;

    // Address width for a RAM of the given depth; never below one bit.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester A/B handshakes plus the single-port RAM side of the arbiter.
// slave = arbiter view, master = requesters + RAM view.
interface ram_arbiter_if #(
    parameter int SIZE  = 8,
    parameter int DEPTH = 256
);
    import ram_arb_pkg::*;

    localparam int AW = addr_w(DEPTH);

    logic            a_req;
    logic            a_lock;
    logic            a_we;
    logic [AW-1:0]   a_addr;
    logic [SIZE-1:0] a_wdata;
    logic            a_ready;
    logic            a_rvalid;
    logic [SIZE-1:0] a_rdata;

    logic            b_req;
    logic            b_lock;
    logic            b_we;
    logic [AW-1:0]   b_addr;
    logic [SIZE-1:0] b_wdata;
    logic            b_ready;
    logic            b_rvalid;
    logic [SIZE-1:0] b_rdata;

    logic [AW-1:0]   ram_address;
    logic [SIZE-1:0] ram_write_data;
    logic            ram_write_en;
    logic [SIZE-1:0] ram_read_data;

    modport slave (
        input  a_req, a_lock, a_we, a_addr, a_wdata,
        output a_ready, a_rvalid, a_rdata,
        input  b_req, b_lock, b_we, b_addr, b_wdata,
        output b_ready, b_rvalid, b_rdata,
        output ram_address, ram_write_data, ram_write_en,
        input  ram_read_data
    );

    modport master (
        output a_req, a_lock, a_we, a_addr, a_wdata,
        input  a_ready, a_rvalid, a_rdata,
        output b_req, b_lock, b_we, b_addr, b_wdata,
        input  b_ready, b_rvalid, b_rdata,
        input  ram_address, ram_write_data, ram_write_en,
        output ram_read_data
    );

endinterface

// File: rtl/ram_arbiter_rr_grant2.sv
// Combinational 2-way grant: a held lock wins, then a lone requester,
// then round-robin against the previous winner.
module rr_grant2
    import ram_arb_pkg::*;
(
    input  logic   en,
    input  logic   a_req,
    input  logic   b_req,
    input  owner_t lock_owner,
    input  owner_t last_grant,
    output logic   grant_a,
    output logic   grant_b
);

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (en) begin
            if (lock_owner == OWN_A && a_req) begin
                grant_a = 1'b1;
            end else if (lock_owner == OWN_B && b_req) begin
                grant_b = 1'b1;
            end else if (a_req && b_req) begin
                // Contention: the side that did not win last time goes now.
                grant_a = (last_grant != OWN_A);
                grant_b = (last_grant == OWN_A);
            end else begin
                grant_a = a_req;
                grant_b = b_req;
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Arbiter/sequencer for one single-port synchronous RAM shared by two
// requesters; optional clear-after-reset, one access per cycle, 1-cycle reads.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int              SIZE           = 8,
    parameter int              DEPTH          = 256,
    parameter bit              CLEAR_ON_RESET = 1'b1,
    parameter logic [SIZE-1:0] INIT_VALUE     = '0
) (
    input  logic           clk,
    input  logic           rst_n,
    ram_arbiter_if.slave   bus,
    output logic           init_done
);

    localparam int AW = addr_w(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t          state, state_n;
    logic [AW-1:0]   count, count_n;
    owner_t          last_grant;
    owner_t          lock_owner;
    logic            rd_pending;
    owner_t          rd_owner;
    logic [AW-1:0]   addr_q;

    logic            grant_a, grant_b;
    logic            ready_a, ready_b;
    logic [AW-1:0]   address_c;
    logic [SIZE-1:0] wdata_c;
    logic            we_c;

    rr_grant2 u_grant (
        .en         (state == ST_ARB),
        .a_req      (bus.a_req),
        .b_req      (bus.b_req),
        .lock_owner (lock_owner),
        .last_grant (last_grant),
        .grant_a    (grant_a),
        .grant_b    (grant_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR_ON_RESET ? ST_INIT : ST_ARB;
            count <= '0;
        end else begin
            state <= state_n;
            count <= count_n;
        end
    end

    always_comb begin
        state_n   = state;
        count_n   = count;
        address_c = addr_q;
        wdata_c   = '0;
        we_c      = 1'b0;
        ready_a   = 1'b0;
        ready_b   = 1'b0;
        case (state)
            ST_INIT: begin
                we_c      = 1'b1;
                address_c = count;
                wdata_c   = INIT_VALUE;
                count_n   = count + 1'b1;
                if (count == LAST_ADDR) begin
                    state_n = ST_ARB;
                    count_n = '0;
                end
            end
            ST_ARB: begin
                if (grant_a) begin
                    ready_a   = 1'b1;
                    we_c      = bus.a_we;
                    address_c = bus.a_addr;
                    wdata_c   = bus.a_wdata;
                end else if (grant_b) begin
                    ready_b   = 1'b1;
                    we_c      = bus.b_we;
                    address_c = bus.b_addr;
                    wdata_c   = bus.b_wdata;
                end
            end
            default: state_n = ST_INIT;
        endcase
        // Reset forces every output quiet even though INIT drives the bus.
        if (!rst_n) begin
            address_c = '0;
            wdata_c   = '0;
            we_c      = 1'b0;
            ready_a   = 1'b0;
            ready_b   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= OWN_B;
            lock_owner <= OWN_NONE;
            rd_pending <= 1'b0;
            rd_owner   <= OWN_NONE;
            addr_q     <= '0;
        end else begin
            addr_q     <= address_c;
            rd_pending <= (grant_a && !bus.a_we) || (grant_b && !bus.b_we);
            if (grant_a) begin
                rd_owner   <= OWN_A;
                last_grant <= OWN_A;
                lock_owner <= bus.a_lock ? OWN_A : OWN_NONE;
            end else if (grant_b) begin
                rd_owner   <= OWN_B;
                last_grant <= OWN_B;
                lock_owner <= bus.b_lock ? OWN_B : OWN_NONE;
            end else begin
                rd_owner   <= OWN_NONE;
                lock_owner <= OWN_NONE;
            end
        end
    end

    assign bus.a_ready        = ready_a;
    assign bus.b_ready        = ready_b;
    assign bus.ram_address    = address_c;
    assign bus.ram_write_data = wdata_c;
    assign bus.ram_write_en   = we_c;

    // RAM output is only meaningful the cycle after a read grant.
    assign bus.a_rvalid = rd_pending && (rd_owner == OWN_A);
    assign bus.b_rvalid = rd_pending && (rd_owner == OWN_B);
    assign bus.a_rdata  = bus.a_rvalid ? bus.ram_read_data : '0;
    assign bus.b_rdata  = bus.b_rvalid ? bus.ram_read_data : '0;

    assign init_done = rst_n && (state == ST_ARB);

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized + directed bench for ram_arbiter with a queue scoreboard for
// read data and a rule-level reference model of grants and RAM contents.
module tb_ram_arbiter;
    import ram_arb_pkg::*;

    localparam int SIZE = 8;
    localparam int DEPTH = 256;
    localparam int AW = 8;
    localparam logic [SIZE-1:0] INIT = 8'h5A;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic init_done;
    always #5 clk = ~clk;

    ram_arbiter_if #(.SIZE(SIZE), .DEPTH(DEPTH)) bus ();

    ram_arbiter #(
        .SIZE(SIZE), .DEPTH(DEPTH), .CLEAR_ON_RESET(1'b1), .INIT_VALUE(INIT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .init_done (init_done)
    );

    // Simple single-port synchronous RAM
    logic [SIZE-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (bus.ram_write_en) mem[bus.ram_address] <= bus.ram_write_data;
        bus.ram_read_data <= mem[bus.ram_address];
    end

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model state
    logic [SIZE-1:0] model_mem [DEPTH];
    owner_t m_last, m_lock;
    logic [AW-1:0] m_addr;
    logic [SIZE-1:0] qa[$];
    logic [SIZE-1:0] qb[$];

    function automatic owner_t exp_grant(input logic ar, input logic br);
        if (m_lock == OWN_A && ar) return OWN_A;
        if (m_lock == OWN_B && br) return OWN_B;
        if (ar && br) return (m_last == OWN_A) ? OWN_B : OWN_A;
        if (ar) return OWN_A;
        if (br) return OWN_B;
        return OWN_NONE;
    endfunction

    // Monitor: pops the scoreboard whenever a requester sees read data
    always @(posedge clk) begin
        #2;
        if (bus.a_rvalid) begin
            if (qa.size() == 0) chk("a_spurious_rvalid", 32'(1), 32'(0));
            else chk("a_rdata", 32'(bus.a_rdata), 32'(qa.pop_front()));
        end else chk("a_rdata_idle_zero", 32'(bus.a_rdata), 32'(0));
        if (bus.b_rvalid) begin
            if (qb.size() == 0) chk("b_spurious_rvalid", 32'(1), 32'(0));
            else chk("b_rdata", 32'(bus.b_rdata), 32'(qb.pop_front()));
        end else chk("b_rdata_idle_zero", 32'(bus.b_rdata), 32'(0));
    end

    task automatic drive(input logic ar, al, aw, input logic [AW-1:0] aa, input logic [SIZE-1:0] ad,
                         input logic br, bl, bw, input logic [AW-1:0] ba, input logic [SIZE-1:0] bd);
        bus.a_req = ar; bus.a_lock = al; bus.a_we = aw; bus.a_addr = aa; bus.a_wdata = ad;
        bus.b_req = br; bus.b_lock = bl; bus.b_we = bw; bus.b_addr = ba; bus.b_wdata = bd;
    endtask

    task automatic chk_quiet(input string name);
        chk(name, 32'({bus.a_ready, bus.b_ready, bus.ram_write_en, bus.ram_address,
                       bus.ram_write_data, bus.a_rvalid, bus.b_rvalid, init_done}), 32'(0));
        chk({name, "_rdata"}, 32'({bus.a_rdata, bus.b_rdata}), 32'(0));
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic step(input logic ar, al, aw, input logic [AW-1:0] aa, input logic [SIZE-1:0] ad,
                        input logic br, bl, bw, input logic [AW-1:0] ba, input logic [SIZE-1:0] bd,
                        output owner_t g);
        drive(ar, al, aw, aa, ad, br, bl, bw, ba, bd);
        #1;
        g = exp_grant(ar, br);
        chk("a_ready", 32'(bus.a_ready), 32'(g == OWN_A));
        chk("b_ready", 32'(bus.b_ready), 32'(g == OWN_B));
        chk("init_done", 32'(init_done), 32'(1));
        case (g)
            OWN_A: begin
                chk("ram_bus_a", 32'({bus.ram_write_en, bus.ram_address, bus.ram_write_data}), 32'({aw, aa, ad}));
                if (aw) model_mem[aa] = ad; else qa.push_back(model_mem[aa]);
                m_addr = aa; m_last = OWN_A; m_lock = al ? OWN_A : OWN_NONE;
            end
            OWN_B: begin
                chk("ram_bus_b", 32'({bus.ram_write_en, bus.ram_address, bus.ram_write_data}), 32'({bw, ba, bd}));
                if (bw) model_mem[ba] = bd; else qb.push_back(model_mem[ba]);
                m_addr = ba; m_last = OWN_B; m_lock = bl ? OWN_B : OWN_NONE;
            end
            default: begin
                chk("ram_idle_hold", 32'({bus.ram_write_en, bus.ram_address}), 32'({1'b0, m_addr}));
                m_lock = OWN_NONE;
            end
        endcase
        @(negedge clk);
    endtask

    // Reset with requests asserted, then walk the full clear sequence.
    task automatic reset_init();
        @(negedge clk);
        chk("a_queue_drained", 32'(qa.size()), 32'(0));
        chk("b_queue_drained", 32'(qb.size()), 32'(0));
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 8'h11, 8'h22, 1'b1, 1'b0, 1'b0, 8'h33, 8'h44);
        #1 chk_quiet("in_reset");
        @(negedge clk);
        chk_quiet("in_reset_after_edge");
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < DEPTH; i++) begin
            chk("init_cycle", 32'({bus.ram_write_en, bus.ram_address, bus.ram_write_data,
                                   bus.a_ready, bus.b_ready, init_done}),
                32'({1'b1, 8'(i), INIT, 1'b0, 1'b0, 1'b0}));
            @(negedge clk);
            #1;
        end
        chk("init_done_cycle_257", 32'(init_done), 32'(1));
        drive(1'b0, 1'b0, 1'b0, 8'h0, 8'h0, 1'b0, 1'b0, 1'b0, 8'h0, 8'h0);
        for (int i = 0; i < DEPTH; i++) model_mem[i] = INIT;
        m_last = OWN_B; m_lock = OWN_NONE; m_addr = AW'(DEPTH - 1);
        qa.delete(); qb.delete();
        @(negedge clk);
    endtask

    logic ha, pal, paw, hb, pbl, pbw;
    logic [AW-1:0] paa, pba;
    logic [SIZE-1:0] pad, pbd;

    task automatic random_phase(input int n);
        ha = 1'b0; hb = 1'b0;
        for (int k = 0; k < n; k++) begin
            owner_t g;
            if (!ha && $urandom_range(0, 99) < 60) begin
                ha = 1'b1; pal = ($urandom_range(0, 3) == 0); paw = 1'($urandom_range(0, 1));
                paa = AW'($urandom_range(0, 7)); pad = SIZE'($urandom);
            end
            if (!hb && $urandom_range(0, 99) < 60) begin
                hb = 1'b1; pbl = ($urandom_range(0, 3) == 0); pbw = 1'($urandom_range(0, 1));
                pba = AW'($urandom_range(0, 7)); pbd = SIZE'($urandom);
            end
            step(ha, ha & pal, ha & paw, paa, pad, hb, hb & pbl, hb & pbw, pba, pbd, g);
            if (g == OWN_A) ha = 1'b0;
            if (g == OWN_B) hb = 1'b0;
        end
        drive(1'b0, 1'b0, 1'b0, 8'h0, 8'h0, 1'b0, 1'b0, 1'b0, 8'h0, 8'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        owner_t g;
        drive(1'b0, 1'b0, 1'b0, 8'h0, 8'h0, 1'b0, 1'b0, 1'b0, 8'h0, 8'h0);
        reset_init();

        // A write then read-after-write of the same address
        step(1'b1, 1'b0, 1'b1, 8'd3, 8'hC4, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00, g);
        step(1'b1, 1'b0, 1'b0, 8'd3, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00, g);
        step(1'b0, 1'b0, 1'b0, 8'd0, 8'h00, 1'b1, 1'b0, 1'b1, 8'd9, 8'h11, g);

        // Both read continuously: alternating grants and rvalids
        for (int k = 0; k < 4; k++)
            step(1'b1, 1'b0, 1'b0, 8'd1, 8'h00, 1'b1, 1'b0, 1'b0, 8'd2, 8'h00, g);

        // A locks the grant against a waiting B, then releases
        step(1'b1, 1'b1, 1'b0, 8'd1, 8'h00, 1'b1, 1'b0, 1'b0, 8'd2, 8'h00, g);
        step(1'b1, 1'b1, 1'b1, 8'd4, 8'h77, 1'b1, 1'b0, 1'b0, 8'd2, 8'h00, g);
        step(1'b1, 1'b0, 1'b0, 8'd4, 8'h00, 1'b1, 1'b0, 1'b0, 8'd2, 8'h00, g);
        step(1'b1, 1'b0, 1'b0, 8'd4, 8'h00, 1'b1, 1'b0, 1'b0, 8'd2, 8'h00, g);
        chk("b_after_lock_release", 32'(g), 32'(OWN_B));

        // Idle: address held, no writes, no read data
        for (int k = 0; k < 5; k++)
            step(1'b0, 1'b0, 1'b0, 8'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00, g);

        random_phase(300);
        repeat (2) @(negedge clk);

        // Reset lands in the middle of a granted read's cycle
        drive(1'b1, 1'b0, 1'b0, 8'd5, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00);
        #1 chk("a_ready_before_abort", 32'(bus.a_ready), 32'(1));
        #2 rst_n = 1'b0;
        #1 chk_quiet("abort_reset");
        @(posedge clk);
        #2 chk("a_rvalid_dropped", 32'(bus.a_rvalid), 32'(0));
        reset_init();

        random_phase(150);
        repeat (3) @(negedge clk);
        chk("a_queue_final", 32'(qa.size()), 32'(0));
        chk("b_queue_final", 32'(qb.size()), 32'(0));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
